// File: rtl/ped_btn_cond.sv
// Pedestrian button conditioner: synchronise, debounce, and turn each accepted press into a PED_SW pulse.
// Optional macro RED_LOCKOUT_EN discards presses that arrive while RED is high.
module ped_btn_cond #(
   parameter int DB_CYC    = 4,
   parameter int PULSE_CYC = 3,
   parameter int CNT_W     = 8
) (
   input  logic             CLK,
   input  logic             RST,
   input  logic             BTN_IN,
   input  logic             RED,
   output logic             PED_SW,
   output logic             PENDING,
   output logic [CNT_W-1:0] PRESS_CNT
);

   typedef enum logic {IDLE, PULSE} state_t;

   localparam logic [15:0] DB_LAST    = 16'(DB_CYC - 1);
   localparam logic [7:0]  PULSE_LOAD = 8'(PULSE_CYC - 1);

   logic        s1, s2;
   logic        db, db_prev, red_d;
   logic [15:0] db_cnt;
   logic [7:0]  pulse_cnt, pulse_cnt_next;
   state_t      state, state_next;
   logic        press, red_rise, accept;

   always_ff @(posedge CLK) begin
      if (RST) begin
         s1 <= 1'b0;
         s2 <= 1'b0;
      end else begin
         s1 <= BTN_IN;
         s2 <= s1;
      end
   end

   // The debounced level only moves after DB_CYC consecutive disagreeing samples.
   always_ff @(posedge CLK) begin
      if (RST) begin
         db      <= 1'b0;
         db_prev <= 1'b0;
         db_cnt  <= '0;
      end else begin
         db_prev <= db;
         if (s2 == db) begin
            db_cnt <= '0;
         end else if (db_cnt == DB_LAST) begin
            db     <= s2;
            db_cnt <= '0;
         end else begin
            db_cnt <= db_cnt + 16'd1;
         end
      end
   end

   assign press    = db & ~db_prev;
   assign red_rise = RED & ~red_d;
   assign PED_SW   = (state == PULSE);

   always_comb begin
      state_next     = state;
      pulse_cnt_next = pulse_cnt;
      accept         = press && (state == IDLE) && !PENDING;
`ifdef RED_LOCKOUT_EN
      if (RED) accept = 1'b0;
`endif
      case (state)
         IDLE: begin
            if (accept) begin
               state_next     = PULSE;
               pulse_cnt_next = PULSE_LOAD;
            end
         end
         PULSE: begin
            if (pulse_cnt == 8'd0) state_next = IDLE;
            else                   pulse_cnt_next = pulse_cnt - 8'd1;
         end
         default: state_next = IDLE;
      endcase
   end

   // A new accepted press outranks a simultaneous RED rise when updating PENDING.
   always_ff @(posedge CLK) begin
      if (RST) begin
         state     <= IDLE;
         pulse_cnt <= '0;
         red_d     <= 1'b0;
         PENDING   <= 1'b0;
         PRESS_CNT <= '0;
      end else begin
         state     <= state_next;
         pulse_cnt <= pulse_cnt_next;
         red_d     <= RED;
         if (accept)        PENDING <= 1'b1;
         else if (red_rise) PENDING <= 1'b0;
         if (accept && (PRESS_CNT != '1)) PRESS_CNT <= PRESS_CNT + CNT_W'(1);
      end
   end

endmodule

// File: tb/tb_ped_btn_cond.sv
// Self-checking bench for ped_btn_cond: vector table, directed corner sequences and a randomized run
// against a queue-based reference model. Honours RED_LOCKOUT_EN when defined.
module tb_ped_btn_cond;

   localparam int DB_CYC    = 4;
   localparam int PULSE_CYC = 3;

   logic       CLK = 1'b0;
   logic       RST, BTN_IN, RED;
   logic       PED_SW, PENDING, PED_SW2, PENDING2;
   logic [7:0] PRESS_CNT;
   logic [1:0] PRESS_CNT2;
   int         checks = 0;
   int         errors = 0;

   always #5 CLK = ~CLK;

   ped_btn_cond #(.DB_CYC(DB_CYC), .PULSE_CYC(PULSE_CYC), .CNT_W(8)) dut (
      .CLK(CLK), .RST(RST), .BTN_IN(BTN_IN), .RED(RED),
      .PED_SW(PED_SW), .PENDING(PENDING), .PRESS_CNT(PRESS_CNT));

   ped_btn_cond #(.DB_CYC(DB_CYC), .PULSE_CYC(PULSE_CYC), .CNT_W(2)) dut2 (
      .CLK(CLK), .RST(RST), .BTN_IN(BTN_IN), .RED(RED),
      .PED_SW(PED_SW2), .PENDING(PENDING2), .PRESS_CNT(PRESS_CNT2));

   task automatic checkOutput(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, got, exp, $time);
      end
   endtask

   task automatic applyStimulus(input logic btn, input logic red, input int n);
      BTN_IN = btn;
      RED    = red;
      repeat (n) @(negedge CLK);
   endtask

   task automatic applyReset();
      RST    = 1'b1;
      BTN_IN = 1'b0;
      RED    = 1'b0;
      repeat (3) @(negedge CLK);
      RST    = 1'b0;
   endtask

   function automatic int capCnt(input int v, input int maxv);
      return (v > maxv) ? maxv : v;
   endfunction

   // Reference model: BTN_IN delay line, window of recent synchronised samples,
   // and pulse timing expressed as the edge index at which the pulse began.
   logic q[$] = '{1'b0, 1'b0};
   logic hist[$];
   int   cyc = 0, pstart = -1000, m_cnt = 0;
   bit   m_db, m_dbprev, m_pend, m_redd, m_ped, model_on = 0;
   logic m_s2;
   bit   m_press, m_accept, m_flip;

   always @(posedge CLK) begin
      if (RST) begin
         q = '{1'b0, 1'b0};
         hist.delete();
         m_db = 0; m_dbprev = 0; m_pend = 0; m_redd = 0; m_ped = 0;
         m_cnt = 0; pstart = -1000;
      end else begin
         m_s2 = q.pop_front();
         q.push_back(BTN_IN);
         m_press  = m_db && !m_dbprev;
         m_accept = m_press && !m_ped && !m_pend;
`ifdef RED_LOCKOUT_EN
         if (RED) m_accept = 0;
`endif
         if (m_accept) begin
            pstart = cyc;
            m_pend = 1;
            m_cnt++;
         end else if (RED && !m_redd) begin
            m_pend = 0;
         end
         m_ped = (cyc >= pstart) && (cyc < pstart + PULSE_CYC);
         hist.push_back(m_s2);
         if (hist.size() > DB_CYC) void'(hist.pop_front());
         m_flip = (hist.size() == DB_CYC);
         foreach (hist[i]) if (hist[i] == m_db) m_flip = 0;
         m_dbprev = m_db;
         if (m_flip) m_db = !m_db;
         m_redd = RED;
      end
      cyc++;
   end

   always @(negedge CLK) begin
      if (model_on) begin
         checkOutput("model_ped",   PED_SW,     m_ped);
         checkOutput("model_pend",  PENDING,    m_pend);
         checkOutput("model_cnt",   PRESS_CNT,  capCnt(m_cnt, 255));
         checkOutput("model_ped2",  PED_SW2,    m_ped);
         checkOutput("model_pend2", PENDING2,   m_pend);
         checkOutput("model_cnt2",  PRESS_CNT2, capCnt(m_cnt, 3));
      end
   end

   typedef struct {
      logic btn;
      logic red;
      int   hold;
      logic ped;
      logic pend;
      int   cnt;
   } vec_t;

   function automatic vec_t mk(input logic btn, input logic red, input int hold,
                               input logic ped, input logic pend, input int cnt);
      vec_t v;
      v.btn = btn; v.red = red; v.hold = hold; v.ped = ped; v.pend = pend; v.cnt = cnt;
      return v;
   endfunction

   vec_t vecs[$];

   initial begin
      RST = 1'b1; BTN_IN = 1'b0; RED = 1'b0;

      // Clean press, absorbed repeats, RED clear, then a fresh press.
      vecs.push_back(mk(1, 0, 6,  0, 0, 0));
      vecs.push_back(mk(1, 0, 1,  1, 1, 1));
      vecs.push_back(mk(1, 0, 2,  1, 1, 1));
      vecs.push_back(mk(1, 0, 1,  0, 1, 1));
      vecs.push_back(mk(1, 0, 20, 0, 1, 1));
      vecs.push_back(mk(0, 0, 10, 0, 1, 1));
      vecs.push_back(mk(1, 0, 10, 0, 1, 1));
      vecs.push_back(mk(0, 0, 10, 0, 1, 1));
      vecs.push_back(mk(1, 0, 10, 0, 1, 1));
      vecs.push_back(mk(0, 0, 10, 0, 1, 1));
      vecs.push_back(mk(0, 1, 1,  0, 0, 1));
      vecs.push_back(mk(0, 0, 3,  0, 0, 1));
      vecs.push_back(mk(1, 0, 6,  0, 0, 1));
      vecs.push_back(mk(1, 0, 1,  1, 1, 2));
      vecs.push_back(mk(1, 0, 2,  1, 1, 2));
      vecs.push_back(mk(1, 0, 1,  0, 1, 2));
      vecs.push_back(mk(0, 0, 10, 0, 1, 2));

      repeat (20) @(negedge CLK);
      checkOutput("reset_ped",  PED_SW,     0);
      checkOutput("reset_pend", PENDING,    0);
      checkOutput("reset_cnt",  PRESS_CNT,  0);
      checkOutput("reset_cnt2", PRESS_CNT2, 0);
      RST = 1'b0;
      model_on = 1;

      foreach (vecs[i]) begin
         applyStimulus(vecs[i].btn, vecs[i].red, vecs[i].hold);
         checkOutput($sformatf("vec%0d_ped", i),  PED_SW,    vecs[i].ped);
         checkOutput($sformatf("vec%0d_pend", i), PENDING,   vecs[i].pend);
         checkOutput($sformatf("vec%0d_cnt", i),  PRESS_CNT, vecs[i].cnt);
      end

      // Bounce: 2-cycle runs never survive the debouncer.
      applyReset();
      for (int i = 0; i < 10; i++) applyStimulus(i[0] ? 1'b0 : 1'b1, 1'b0, 2);
      applyStimulus(0, 0, 15);
      checkOutput("bounce_cnt",  PRESS_CNT, 0);
      checkOutput("bounce_pend", PENDING,   0);

      // Glitch boundary: DB_CYC-1 high cycles rejected, DB_CYC accepted.
      for (int h = DB_CYC - 1; h <= DB_CYC; h++) begin
         applyReset();
         applyStimulus(1, 0, h);
         applyStimulus(0, 0, 12);
         checkOutput($sformatf("glitch%0d_cnt", h), PRESS_CNT, (h >= DB_CYC) ? 1 : 0);
      end

      // Reset in the second PED_SW-high cycle, button held through reset release.
      applyReset();
      applyStimulus(1, 0, 8);
      checkOutput("midrst_pre_ped", PED_SW, 1);
      RST = 1'b1;
      @(negedge CLK);
      checkOutput("midrst_ped",  PED_SW,    0);
      checkOutput("midrst_pend", PENDING,   0);
      checkOutput("midrst_cnt",  PRESS_CNT, 0);
      RST = 1'b0;
      applyStimulus(1, 0, DB_CYC + 2);
      checkOutput("relrst_early_ped", PED_SW, 0);
      applyStimulus(1, 0, 1);
      checkOutput("relrst_ped", PED_SW,    1);
      checkOutput("relrst_cnt", PRESS_CNT, 1);
      applyStimulus(1, 0, PULSE_CYC);
      checkOutput("relrst_end_ped", PED_SW, 0);
      applyStimulus(1, 0, 20);
      checkOutput("relrst_hold_cnt", PRESS_CNT, 1);

      // Press while RED is already high.
      applyReset();
      RED = 1'b1;
      applyStimulus(1, 1, DB_CYC + 3);
`ifdef RED_LOCKOUT_EN
      checkOutput("lockout_ped", PED_SW,    0);
      checkOutput("lockout_cnt", PRESS_CNT, 0);
`else
      checkOutput("lockout_ped", PED_SW,    1);
      checkOutput("lockout_cnt", PRESS_CNT, 1);
`endif
      applyStimulus(0, 0, 12);

      // Saturation of the 2-bit counter.
      applyReset();
      for (int i = 1; i <= 5; i++) begin
         applyStimulus(1, 0, DB_CYC + 3);
         checkOutput($sformatf("sat%0d_ped", i),  PED_SW,     1);
         checkOutput($sformatf("sat%0d_cnt2", i), PRESS_CNT2, (i > 3) ? 3 : i);
         checkOutput($sformatf("sat%0d_cnt", i),  PRESS_CNT,  i);
         applyStimulus(1, 0, 8);
         applyStimulus(0, 0, 10);
         applyStimulus(0, 1, 1);
         applyStimulus(0, 0, 2);
      end

      // Randomized bursts with occasional RED pulses and resets.
      applyReset();
      for (int i = 0; i < 300; i++) begin
         RST = ($urandom_range(0, 60) == 0);
         applyStimulus(1'($urandom_range(0, 1)), ($urandom_range(0, 5) == 0),
                       $urandom_range(1, 12));
         RST = 1'b0;
      end
      applyStimulus(0, 0, 5);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
